// File: rtl/clct_gem_offset_lut_if.sv
// CLCT lookup and host-table bus for the GEM-CSC bending-offset LUT.
// The slave modport is the LUT side; the master modport is the matcher/host side.
interface clct_gem_offset_lut_if #(
  parameter int NCLCT  = 2,
  parameter int MXADRB = 4,
  parameter int MXDATB = 8,
  parameter int MXKEYB = 10
);
  logic                     clct_vld;
  logic [NCLCT*MXADRB-1:0]  clct_bend;
  logic [NCLCT*MXKEYB-1:0]  clct_key;
  logic [NCLCT-1:0]         is_me1a;
  logic                     even;
  logic                     gem_vld;
  logic [NCLCT*MXDATB-1:0]  gemA_offset;
  logic [NCLCT*MXDATB-1:0]  gemB_offset;
  logic [NCLCT*MXKEYB-1:0]  gemA_key;
  logic [NCLCT*MXKEYB-1:0]  gemB_key;
  logic                     lut_wr;
  logic [2:0]               lut_sel;
  logic [MXADRB-1:0]        lut_adr;
  logic [MXDATB-1:0]        lut_wdata;
  logic [MXDATB-1:0]        lut_rdata;
  logic                     lut_ready;

  modport master (
    output clct_vld, clct_bend, clct_key, is_me1a, even,
    output lut_wr, lut_sel, lut_adr, lut_wdata,
    input  gem_vld, gemA_offset, gemB_offset, gemA_key, gemB_key,
    input  lut_rdata, lut_ready
  );

  modport slave (
    input  clct_vld, clct_bend, clct_key, is_me1a, even,
    input  lut_wr, lut_sel, lut_adr, lut_wdata,
    output gem_vld, gemA_offset, gemB_offset, gemA_key, gemB_key,
    output lut_rdata, lut_ready
  );
endinterface

// File: rtl/clct_gem_offset_lut.sv
// Host-loadable GEM-CSC bending-offset tables with a 2-stage lookup returning offsets and
// GEM-projected, range-clamped 1/8-strip keys; tables are cleared one entry per cycle after reset.
module clct_gem_offset_lut #(
  parameter int NCLCT       = 2,
  parameter int MXADRB      = 4,
  parameter int MXDATB      = 8,
  parameter int MXKEYB      = 10,
  parameter int KEYMAX_ME1B = 511,
  parameter int KEYMAX_ME1A = 383
) (
  input logic                   clock,
  input logic                   global_reset,
  clct_gem_offset_lut_if.slave  bus
);
  localparam int ENTB = MXADRB + 3;
  localparam int NENT = 8 * (2**MXADRB);
  localparam int SUMB = MXKEYB + 2;
  localparam logic [0:0] INIT  = 1'b0;
  localparam logic [0:0] READY = 1'b1;
  localparam logic [ENTB-1:0] LASTENT = '1;
  localparam logic signed [SUMB-1:0] LIMA = SUMB'(KEYMAX_ME1A);
  localparam logic signed [SUMB-1:0] LIMB = SUMB'(KEYMAX_ME1B);

  logic [0:0]        state;
  logic [ENTB-1:0]   initCnt;
  logic              ready;
  logic [MXDATB-1:0] lut [NENT];

  logic              s1Vld;
  logic [NCLCT-1:0]  s1Me1a;
  logic [MXKEYB-1:0] s1Key  [NCLCT];
  logic [MXDATB-1:0] s1OffA [NCLCT];
  logic [MXDATB-1:0] s1OffB [NCLCT];

  // Key plus signed offset, kept two bits wider so both underflow and overflow are visible.
  function automatic logic [MXKEYB-1:0] clampKey(input logic [MXKEYB-1:0] key,
                                                 input logic [MXDATB-1:0] off,
                                                 input logic              me1a);
    logic signed [SUMB-1:0] sum;
    logic signed [SUMB-1:0] lim;
    sum = $signed({2'b00, key}) + $signed({{(SUMB-MXDATB){off[MXDATB-1]}}, off});
    lim = me1a ? LIMA : LIMB;
    if (sum[SUMB-1])
      return '0;
    else if (sum > lim)
      return lim[MXKEYB-1:0];
    else
      return sum[MXKEYB-1:0];
  endfunction

  assign ready         = (state == READY);
  assign bus.lut_ready = ready;

  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      state   <= INIT;
      initCnt <= '0;
    end else if (state == INIT) begin
      if (initCnt == LASTENT)
        state <= READY;
      else
        initCnt <= initCnt + 1'b1;
    end
  end

  // Table storage has no reset; the INIT sweep is what makes its contents valid.
  always_ff @(posedge clock) begin
    if (state == INIT)
      lut[initCnt] <= '0;
    else if (bus.lut_wr)
      lut[{bus.lut_sel, bus.lut_adr}] <= bus.lut_wdata;
  end

  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset)
      bus.lut_rdata <= '0;
    else
      bus.lut_rdata <= ready ? lut[{bus.lut_sel, bus.lut_adr}] : '0;
  end

  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      s1Vld  <= 1'b0;
      s1Me1a <= '0;
      for (int n = 0; n < NCLCT; n++) begin
        s1Key[n]  <= '0;
        s1OffA[n] <= '0;
        s1OffB[n] <= '0;
      end
    end else begin
      s1Vld <= bus.clct_vld;
      if (bus.clct_vld) begin
        s1Me1a <= bus.is_me1a;
        for (int n = 0; n < NCLCT; n++) begin
          s1Key[n]  <= bus.clct_key[n*MXKEYB +: MXKEYB];
          s1OffA[n] <= ready ? lut[{bus.is_me1a[n], bus.even, 1'b0, bus.clct_bend[n*MXADRB +: MXADRB]}] : '0;
          s1OffB[n] <= ready ? lut[{bus.is_me1a[n], bus.even, 1'b1, bus.clct_bend[n*MXADRB +: MXADRB]}] : '0;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      bus.gem_vld     <= 1'b0;
      bus.gemA_offset <= '0;
      bus.gemB_offset <= '0;
      bus.gemA_key    <= '0;
      bus.gemB_key    <= '0;
    end else begin
      bus.gem_vld <= s1Vld;
      if (s1Vld) begin
        for (int n = 0; n < NCLCT; n++) begin
          bus.gemA_offset[n*MXDATB +: MXDATB] <= s1OffA[n];
          bus.gemB_offset[n*MXDATB +: MXDATB] <= s1OffB[n];
          bus.gemA_key[n*MXKEYB +: MXKEYB]    <= clampKey(s1Key[n], s1OffA[n], s1Me1a[n]);
          bus.gemB_key[n*MXKEYB +: MXKEYB]    <= clampKey(s1Key[n], s1OffB[n], s1Me1a[n]);
        end
      end
    end
  end
endmodule

// File: tb/tb_clct_gem_offset_lut.sv
// Bench for clct_gem_offset_lut: random lookups and host writes scored against a table model,
// plus directed init-length, sign, clamp and reset-during-init cases.
module tb_clct_gem_offset_lut;
  localparam int NC = 2;
  localparam int AB = 4;
  localparam int DB = 8;
  localparam int KB = 10;
  localparam int NENT = 128;

  typedef struct {
    bit              vld;
    logic [NC*DB-1:0] offA;
    logic [NC*DB-1:0] offB;
    logic [NC*KB-1:0] keyA;
    logic [NC*KB-1:0] keyB;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  clct_gem_offset_lut_if #(.NCLCT(NC), .MXADRB(AB), .MXDATB(DB), .MXKEYB(KB)) bus ();

  clct_gem_offset_lut dut (
    .clock        (clk),
    .global_reset (rst),
    .bus          (bus)
  );

  int total = 0;
  int bad = 0;
  int edges = 0;
  int lowCnt;
  ent_t q[$];
  logic [DB-1:0] tbl [8][16];
  bit            rdChk;
  logic [DB-1:0] rdExp;
  logic [NC*DB-1:0] heldOffA, heldOffB;
  logic [NC*KB-1:0] heldKeyA, heldKeyB;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int refKey(input int key, input int off, input bit me1a);
    int lim = me1a ? 383 : 511;
    int s = key + off;
    if (s < 0) return 0;
    if (s > lim) return lim;
    return s;
  endfunction

  task automatic idle();
    bus.clct_vld  = 1'b0;
    bus.clct_bend = '0;
    bus.clct_key  = '0;
    bus.is_me1a   = '0;
    bus.even      = 1'b0;
    bus.lut_wr    = 1'b0;
    bus.lut_sel   = '0;
    bus.lut_adr   = '0;
    bus.lut_wdata = '0;
  endtask

  // One clock: score the current inputs with the model, advance, then check what is due.
  task automatic tick();
    ent_t e;
    bit   mReady = (edges >= NENT);
    e.vld = bus.clct_vld;
    for (int n = 0; n < NC; n++) begin
      int bend = int'(bus.clct_bend[n*AB +: AB]);
      int key  = int'(bus.clct_key[n*KB +: KB]);
      bit me   = bus.is_me1a[n];
      logic [DB-1:0] oa = mReady ? tbl[{me, bus.even, 1'b0}][bend] : 8'h00;
      logic [DB-1:0] ob = mReady ? tbl[{me, bus.even, 1'b1}][bend] : 8'h00;
      e.offA[n*DB +: DB] = oa;
      e.offB[n*DB +: DB] = ob;
      e.keyA[n*KB +: KB] = KB'(refKey(key, int'($signed(oa)), me));
      e.keyB[n*KB +: KB] = KB'(refKey(key, int'($signed(ob)), me));
    end
    q.push_back(e);
    rdChk = mReady;
    rdExp = tbl[bus.lut_sel][bus.lut_adr];
    if (mReady && bus.lut_wr) tbl[bus.lut_sel][bus.lut_adr] = bus.lut_wdata;
    @(posedge clk);
    @(negedge clk);
    edges++;
    checkEq("lut_ready", 32'(bus.lut_ready), 32'(edges >= NENT));
    if (rdChk) checkEq("lut_rdata", 32'(bus.lut_rdata), 32'(rdExp));
    if (q.size() == 2) begin
      e = q.pop_front();
      checkEq("gem_vld", 32'(bus.gem_vld), 32'(e.vld));
      if (e.vld) begin
        heldOffA = e.offA; heldOffB = e.offB;
        heldKeyA = e.keyA; heldKeyB = e.keyB;
      end
      checkEq("gemA_offset", 32'(bus.gemA_offset), 32'(heldOffA));
      checkEq("gemB_offset", 32'(bus.gemB_offset), 32'(heldOffB));
      checkEq("gemA_key", 32'(bus.gemA_key), 32'(heldKeyA));
      checkEq("gemB_key", 32'(bus.gemB_key), 32'(heldKeyB));
    end
  endtask

  task automatic doReset();
    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    q.delete();
    edges = 0;
    heldOffA = '0; heldOffB = '0; heldKeyA = '0; heldKeyB = '0;
    for (int s = 0; s < 8; s++)
      for (int a = 0; a < 16; a++) tbl[s][a] = '0;
    checkEq("rst_gem_vld", 32'(bus.gem_vld), 32'd0);
    checkEq("rst_offsets", 32'({bus.gemA_offset, bus.gemB_offset}), 32'd0);
    checkEq("rst_keyA", 32'(bus.gemA_key), 32'd0);
    checkEq("rst_keyB", 32'(bus.gemB_key), 32'd0);
    checkEq("rst_rdata", 32'(bus.lut_rdata), 32'd0);
    checkEq("rst_ready", 32'(bus.lut_ready), 32'd0);
    rst = 1'b0;
  endtask

  // Runs the init window with host writes hammering (they must be ignored) and measures its length.
  task automatic runInit();
    lowCnt = bus.lut_ready ? 0 : 1;
    for (int i = 0; i < 200 && !bus.lut_ready; i++) begin
      bus.lut_wr    = 1'b1;
      bus.lut_sel   = 3'($urandom);
      bus.lut_adr   = 4'($urandom);
      bus.lut_wdata = 8'($urandom_range(1, 255));
      tick();
      if (!bus.lut_ready) lowCnt++;
    end
    idle();
    checkEq("init_len", 32'(lowCnt), 32'd128);
    checkEq("init_done", 32'(bus.lut_ready), 32'd1);
  endtask

  task automatic sweepReadback();
    for (int i = 0; i < NENT; i++) begin
      bus.lut_sel = 3'(i >> 4);
      bus.lut_adr = 4'(i);
      tick();
    end
    idle();
    tick();
  endtask

  task automatic hostWrite(input logic [2:0] sel, input logic [3:0] adr, input logic [7:0] dat);
    idle();
    bus.lut_wr = 1'b1; bus.lut_sel = sel; bus.lut_adr = adr; bus.lut_wdata = dat;
    tick();
    idle();
  endtask

  initial begin
    idle();
    doReset();
    runInit();
    sweepReadback();

    // Positive offset on layer A, ME1b even.
    hostWrite(3'b010, 4'd5, 8'd12);
    bus.clct_vld = 1'b1; bus.clct_bend[3:0] = 4'd5; bus.clct_key[9:0] = 10'd100;
    bus.is_me1a = 2'b00; bus.even = 1'b1;
    tick(); idle(); tick();
    checkEq("dir_offA0", 32'(bus.gemA_offset[7:0]), 32'h0c);
    checkEq("dir_keyA0", 32'(bus.gemA_key[9:0]), 32'd112);

    // Negative offset on layer B clamps at zero.
    hostWrite(3'b011, 4'd2, 8'hec);
    bus.clct_vld = 1'b1; bus.clct_bend[3:0] = 4'd2; bus.clct_key[9:0] = 10'd10;
    bus.is_me1a = 2'b00; bus.even = 1'b1;
    tick(); idle(); tick();
    checkEq("dir_offB0", 32'(bus.gemB_offset[7:0]), 32'hec);
    checkEq("dir_keyB0", 32'(bus.gemB_key[9:0]), 32'd0);

    // +8 on key 380: ME1a clamps to 383, ME1b passes through.
    hostWrite(3'b100, 4'd7, 8'd8);
    hostWrite(3'b101, 4'd7, 8'd8);
    hostWrite(3'b000, 4'd7, 8'd8);
    hostWrite(3'b001, 4'd7, 8'd8);
    bus.clct_vld = 1'b1; bus.clct_bend = {4'd7, 4'd7}; bus.clct_key = {10'd380, 10'd380};
    bus.is_me1a = 2'b01; bus.even = 1'b0;
    tick(); idle(); tick();
    checkEq("clamp_me1a_A", 32'(bus.gemA_key[9:0]), 32'd383);
    checkEq("clamp_me1a_B", 32'(bus.gemB_key[9:0]), 32'd383);
    checkEq("pass_me1b_A", 32'(bus.gemA_key[19:10]), 32'd388);
    checkEq("pass_me1b_B", 32'(bus.gemB_key[19:10]), 32'd388);

    // Random traffic: mixed channels, back-to-back valids, writes racing lookups.
    for (int i = 0; i < 600; i++) begin
      bus.clct_vld  = ($urandom_range(0, 3) != 0);
      bus.clct_bend = 8'($urandom);
      bus.clct_key  = {10'($urandom_range(0, 600)), 10'($urandom_range(0, 600))};
      bus.is_me1a   = 2'($urandom);
      bus.even      = 1'($urandom);
      bus.lut_wr    = ($urandom_range(0, 2) == 0);
      bus.lut_sel   = 3'($urandom);
      bus.lut_adr   = ($urandom_range(0, 3) == 0) ? bus.clct_bend[3:0] : 4'($urandom);
      bus.lut_wdata = 8'($urandom);
      tick();
    end
    idle();
    tick(); tick();

    // Reset pulsed partway through init must restart the full sweep.
    doReset();
    for (int i = 0; i < 60; i++) tick();
    doReset();
    runInit();
    sweepReadback();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
